// File: rtl/addsub_seq_arbiter.sv
// -----------------------------------------------------------------------------
// addsub_seq_arbiter
//
// Two-requester arbiter in front of a nibble-serial adder/subtractor. One 4-bit
// full-adder slice handles WIDTH/4 nibbles, LSB first, one nibble per clock.
// Ties go to the requester that was not granted last. Requester 0 wins the
// first tie after reset.
//
// Optional feature: define ADDSUB_SEQ_OVF_EN to add the signed-overflow output
// ovf. Without the macro there is no ovf port and no overflow logic.
//
// Ports
//   clk              sole clock, rising edge
//   rst_n            asynchronous active-low reset
//   req0 / req1      operation request, held high until acked
//   sub0 / sub1      0 = A+B, 1 = A-B
//   a0, b0 / a1, b1  operands (WIDTH bits)
//   ack0 / ack1      one-cycle pulse: request accepted, operands latched
//   busy             high while an operation is running or finishing
//   done             one-cycle pulse: result valid
//   done_id          requester that owns the current result
//   result           sum or difference, held until the next done
//   cout             final carry out (for subtract, 1 = no borrow)
//   ovf              (ADDSUB_SEQ_OVF_EN only) signed overflow, held like result
// -----------------------------------------------------------------------------
module addsub_seq_arbiter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic             req1,
   input  logic             sub0,
   input  logic             sub1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             ack0,
   output logic             ack1,
   output logic             busy,
   output logic             done,
   output logic             done_id,
   output logic [WIDTH-1:0] result,
   output logic             cout
`ifdef ADDSUB_SEQ_OVF_EN
   ,output logic            ovf
`endif
);

   localparam int NIBS  = WIDTH / 4;
   localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;

   logic               start;
   logic               grant_id;
   logic               sel_sub;
   logic [WIDTH-1:0]   sel_a;
   logic [WIDTH-1:0]   sel_b;

   logic               last_grant;
   logic               cur_id;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [WIDTH-1:0]   acc;
   logic               carry;
   logic [IDX_W-1:0]   idx;

   logic               last_nib;
   logic [4:0]         nib_sum;
   logic [WIDTH+3:0]   acc_ext;
   logic [WIDTH-1:0]   acc_next;

   assign busy     = (state != IDLE);
   assign last_nib = (idx == IDX_W'(NIBS - 1));

   // Shared nibble slice: always works on the low nibble of the shifting
   // operand registers.
   assign nib_sum  = {1'b0, op_a[3:0]} + {1'b0, op_b[3:0]} + {4'b0000, carry};

   // New nibble enters at the top; after NIBS shifts the LSB nibble sits at
   // bit 0. Done through a widened vector so WIDTH = 4 needs no special case.
   assign acc_ext  = {nib_sum[3:0], acc};
   assign acc_next = acc_ext[WIDTH+3:4];

`ifdef ADDSUB_SEQ_OVF_EN
   // Carry into the MSB of the final nibble, needed for signed overflow.
   logic [3:0] low3_sum;
   logic       carry_msb;
   assign low3_sum  = {1'b0, op_a[2:0]} + {1'b0, op_b[2:0]} + {3'b000, carry};
   assign carry_msb = low3_sum[3];
`endif

   // -------------------------------------------------------------------------
   // FSM state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // -------------------------------------------------------------------------
   // Next state and arbitration
   // -------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      start      = 1'b0;
      grant_id   = 1'b0;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               start      = 1'b1;
               state_next = RUN;
               // Tie: give it to whoever did not win last time.
               grant_id   = (req0 && req1) ? ~last_grant : req1;
            end
         end
         RUN: begin
            if (last_nib) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      sel_sub = grant_id ? sub1 : sub0;
      sel_a   = grant_id ? a1   : a0;
      sel_b   = grant_id ? b1   : b0;
   end

   // -------------------------------------------------------------------------
   // Operand latch, nibble datapath and result registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack0       <= 1'b0;
         ack1       <= 1'b0;
         done       <= 1'b0;
         done_id    <= 1'b0;
         result     <= '0;
         cout       <= 1'b0;
         last_grant <= 1'b1;
         cur_id     <= 1'b0;
         op_a       <= '0;
         op_b       <= '0;
         acc        <= '0;
         carry      <= 1'b0;
         idx        <= '0;
`ifdef ADDSUB_SEQ_OVF_EN
         ovf        <= 1'b0;
`endif
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         done <= 1'b0;
         if (start) begin
            // Subtract as A + ~B + 1: invert B now, seed carry with 1.
            op_a       <= sel_a;
            op_b       <= sel_sub ? ~sel_b : sel_b;
            carry      <= sel_sub;
            idx        <= '0;
            cur_id     <= grant_id;
            last_grant <= grant_id;
            ack0       <= ~grant_id;
            ack1       <= grant_id;
         end else if (state == RUN) begin
            op_a  <= op_a >> 4;
            op_b  <= op_b >> 4;
            carry <= nib_sum[4];
            acc   <= acc_next;
            idx   <= idx + 1'b1;
            if (last_nib) begin
               result  <= acc_next;
               cout    <= nib_sum[4];
               done_id <= cur_id;
               done    <= 1'b1;
`ifdef ADDSUB_SEQ_OVF_EN
               ovf     <= carry_msb ^ nib_sum[4];
`endif
            end
         end
      end
   end

endmodule
